// File: rtl/reflet_ram_responder.sv
// reflet_ram_responder
//
// Memory-side responder for the Reflet CPU RAM bus. It answers aligned word
// reads and writes from an internal RAM with a one-cycle read latency. It also
// contains a byte-stream program loader. The loader holds the CPU in reset,
// fills the RAM from a length-prefixed little-endian image, and then releases
// the CPU.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-low reset
//   addr          CPU byte address (low log2(bytes per word) bits ignored)
//   data_in       CPU write data
//   write_en      CPU write strobe
//   data_out      registered read data (0 when out of range or loading)
//   out_of_range  registered pulse: the previous access had addr >= mem_bytes
//   load_start    request to begin loading an image (only honoured in RUN)
//   load_data     loader byte
//   load_valid    loader byte valid
//   load_ready    responder accepts a loader byte
//   cpu_reset     active-low reset to the CPU (0 holds the CPU)
//   loading       high while the loader is not in RUN
module reflet_ram_responder #(
    parameter int wordsize  = 16,
    parameter int mem_bytes = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic                out_of_range,
    input  logic                load_start,
    input  logic [7:0]          load_data,
    input  logic                load_valid,
    output logic                load_ready,
    output logic                cpu_reset,
    output logic                loading
);

    localparam int bytes_per_word = wordsize / 8;
    localparam int lane_bits      = $clog2(bytes_per_word);
    localparam int words          = mem_bytes / bytes_per_word;
    localparam int index_bits     = (words > 1) ? $clog2(words) : 1;
    localparam logic [15:0] lane_mask = 16'(bytes_per_word - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_RELEASE
    } state_t;

    logic [wordsize-1:0] mem [words];

    state_t              state, next_state;
    logic [15:0]         len, len_next;
    logic [15:0]         cnt, cnt_next;
    logic [wordsize-1:0] hold, hold_next;
    logic                rel_cnt, rel_cnt_next;

    logic                  ld_we;
    logic [index_bits-1:0] ld_index;
    logic [wordsize-1:0]   ld_word;
    logic [15:0]           lane;
    logic [wordsize-1:0]   assembled;
    logic                  last;

    // CPU side decode. The 64-bit compare covers geometries where mem_bytes
    // exceeds the address range (every address is then in range).
    logic                  in_range;
    logic [index_bits-1:0] cpu_index;
    logic                  cpu_we;
    logic                  read_active;

    assign in_range    = (64'(addr) < 64'(mem_bytes));
    assign cpu_index   = index_bits'(addr >> lane_bits);
    assign cpu_we      = (state == ST_RUN) && write_en && in_range;
    // Gate on the state the read result becomes visible in.
    assign read_active = (next_state == ST_RUN);

    // Loader FSM: next state, datapath next values and outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        next_state   = state;
        len_next     = len;
        cnt_next     = cnt;
        hold_next    = hold;
        rel_cnt_next = rel_cnt;
        ld_we        = 1'b0;
        ld_index     = '0;
        ld_word      = '0;
        lane         = '0;
        assembled    = '0;
        last         = 1'b0;
        load_ready   = 1'b0;
        cpu_reset    = 1'b0;
        loading      = 1'b1;

        case (state)
            ST_RUN: begin
                cpu_reset = 1'b1;
                loading   = 1'b0;
                if (load_start) next_state = ST_LEN0;
            end
            ST_LEN0: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    len_next[7:0] = load_data;
                    next_state    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    len_next[15:8] = load_data;
                    cnt_next       = '0;
                    hold_next      = '0;
                    rel_cnt_next   = 1'b0;
                    next_state     = ({load_data, len[7:0]} == 16'd0) ? ST_RELEASE : ST_DATA;
                end
            end
            ST_DATA: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    lane = cnt & lane_mask;
                    // Lane 0 opens a fresh word, so unfilled upper lanes stay 0.
                    assembled = (lane == 16'd0) ? '0 : hold;
                    assembled = assembled | (wordsize'(load_data) << {lane, 3'b000});
                    last      = (cnt == len - 16'd1);
                    ld_index  = index_bits'(cnt >> lane_bits);
                    ld_word   = assembled;
                    // Bytes past the end of RAM are consumed but never stored.
                    ld_we     = ((lane == lane_mask) || last) &&
                                ({16'd0, cnt} < 32'(mem_bytes));
                    hold_next = assembled;
                    cnt_next  = cnt + 16'd1;
                    if (last) begin
                        next_state   = ST_RELEASE;
                        rel_cnt_next = 1'b0;
                    end
                end
            end
            ST_RELEASE: begin
                if (rel_cnt) next_state = ST_RUN;
                else         rel_cnt_next = 1'b1;
            end
            default: next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_RUN;
            len     <= '0;
            cnt     <= '0;
            hold    <= '0;
            rel_cnt <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state   <= next_state;
            len     <= len_next;
            cnt     <= cnt_next;
            hold    <= hold_next;
            rel_cnt <= rel_cnt_next;
        end
    end

    // Registered read port; read-first against a same-edge write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out     <= '0;
            out_of_range <= 1'b0;
        end else begin
            data_out     <= (read_active && in_range) ? mem[cpu_index] : '0;
            out_of_range <= read_active && !in_range;
        end
    end

    // Single write port shared by CPU and loader; they are never active in the
    // same state, so the priority order never matters in practice.
    // NOTE: the RAM has no reset so it maps onto block RAM and keeps its image.
    always_ff @(posedge clk) begin
        if (cpu_we)     mem[cpu_index] <= data_in;
        else if (ld_we) mem[ld_index]  <= ld_word;
    end

endmodule

// File: tb/tb_reflet_ram_responder.sv
// Self-checking bench for reflet_ram_responder (wordsize=16, mem_bytes=1024).
// A byte-image model of the RAM predicts every read; loads are predicted by
// packing the image bytes into little-endian words.
module tb_reflet_ram_responder;

    localparam int WS    = 16;
    localparam int MEMB  = 1024;
    localparam int WORDS = MEMB / 2;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [WS-1:0] addr = '0;
    logic [WS-1:0] data_in = '0;
    logic          write_en = 1'b0;
    logic [WS-1:0] data_out;
    logic          out_of_range;
    logic          load_start = 1'b0;
    logic [7:0]    load_data = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic          cpu_reset;
    logic          loading;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] model [WORDS];

    reflet_ram_responder #(.wordsize(WS), .mem_bytes(MEMB)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .data_in      (data_in),
        .write_en     (write_en),
        .data_out     (data_out),
        .out_of_range (out_of_range),
        .load_start   (load_start),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .cpu_reset    (cpu_reset),
        .loading      (loading)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < WORDS; i++) begin
            addr     = 16'(i * 2);
            write_en = 1'b0;
            tick();
            check($sformatf("%s_w%0d", tag, i), data_out, model[i]);
        end
    endtask

    // Expected RAM after a load: byte k lands in lane k%2 of word k/2; a final
    // odd byte gives a zero upper lane; bytes beyond the RAM are dropped.
    task automatic model_load(input bq_t img);
        int len;
        logic [7:0] lo, hi;
        len = int'({img[1], img[0]});
        for (int w = 0; 2 * w < len; w++) begin
            if (2 * w < MEMB) begin
                lo = img[2 + 2 * w];
                hi = (2 * w + 1 < len) ? img[3 + 2 * w] : 8'h00;
                model[w] = {hi, lo};
            end
        end
    endtask

    // Drives a full load; the CPU keeps issuing random writes throughout,
    // which must all be ignored.
    task automatic run_load(input bq_t img, input bit toggle, input bit poke_start, input string tag);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check({tag, "_start_cpu_reset"}, cpu_reset, 0);
        check({tag, "_start_ready"}, load_ready, 1);
        check({tag, "_start_loading"}, loading, 1);
        check({tag, "_start_data_out"}, data_out, 0);
        for (int i = 0; i < img.size(); i++) begin
            if (toggle && (i % 2 == 1)) begin
                load_valid = 1'b0;
                addr       = 16'($urandom() & 32'hFFFE);
                data_in    = 16'($urandom());
                write_en   = 1'b1;
                tick();
                check({tag, "_idle_cpu_reset"}, cpu_reset, 0);
                check({tag, "_idle_data_out"}, data_out, 0);
                check({tag, "_idle_oor"}, out_of_range, 0);
            end
            if (poke_start && i == 4) load_start = 1'b1;
            check($sformatf("%s_ready_b%0d", tag, i), load_ready, 1);
            load_valid = 1'b1;
            load_data  = img[i];
            addr       = 16'($urandom() & 32'hFFFE);
            data_in    = 16'($urandom());
            write_en   = 1'b1;
            tick();
            load_start = 1'b0;
        end
        load_valid = 1'b0;
        write_en   = 1'b0;
        check({tag, "_rel1_cpu_reset"}, cpu_reset, 0);
        check({tag, "_rel1_loading"}, loading, 1);
        check({tag, "_rel1_ready"}, load_ready, 0);
        tick();
        check({tag, "_rel2_cpu_reset"}, cpu_reset, 0);
        check({tag, "_rel2_loading"}, loading, 1);
        tick();
        check({tag, "_run_cpu_reset"}, cpu_reset, 1);
        check({tag, "_run_loading"}, loading, 0);
        check({tag, "_run_ready"}, load_ready, 0);
        model_load(img);
    endtask

    initial begin
        bq_t img;
        logic [15:0] a, d, exp_d;
        logic we, in_r;
        logic [7:0] b0, b1, b2;
        int n;

        // Reset
        reset = 1'b0;
        tick();
        tick();
        check("rst_data_out", data_out, 0);
        check("rst_oor", out_of_range, 0);
        check("rst_ready", load_ready, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_loading", loading, 0);
        reset = 1'b1;

        // Fill the RAM with random words so every later read is defined.
        for (int i = 0; i < WORDS; i++) begin
            model[i] = 16'($urandom());
            addr     = 16'(i * 2);
            data_in  = model[i];
            write_en = 1'b1;
            tick();
        end
        write_en = 1'b0;
        sweep("init");

        // Directed read/write with read-first behaviour.
        addr = 16'h0010; data_in = 16'hBEEF; write_en = 1'b1;
        tick();
        check("rw_read_first_old", data_out, model[8]);
        model[8] = 16'hBEEF;
        write_en = 1'b0;
        tick();
        check("rw_beef", data_out, 16'hBEEF);
        data_in = 16'h1234; write_en = 1'b1;
        tick();
        check("rw_same_cycle_old", data_out, 16'hBEEF);
        write_en = 1'b0;
        tick();
        check("rw_new", data_out, 16'h1234);
        model[8] = 16'h1234;

        // Out-of-range boundary.
        addr = 16'h0400; data_in = 16'hAAAA; write_en = 1'b1;
        tick();
        check("oor_write_pulse", out_of_range, 1);
        check("oor_write_data", data_out, 0);
        addr = 16'h0000; write_en = 1'b0;
        tick();
        check("oor_clear", out_of_range, 0);
        check("oor_mem0_unchanged", data_out, model[0]);
        addr = 16'h0400;
        tick();
        check("oor_read_data", data_out, 0);
        check("oor_read_pulse", out_of_range, 1);
        addr = 16'h03FE;
        tick();
        check("oor_last_word_flag", out_of_range, 0);
        check("oor_last_word_data", data_out, model[WORDS-1]);

        // Random CPU traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(MEMB, 65535)) & 16'hFFFE;
            else                           a = 16'($urandom_range(0, WORDS - 1) * 2);
            we    = 1'($urandom_range(0, 1));
            d     = 16'($urandom());
            in_r  = (a < 16'(MEMB));
            exp_d = in_r ? model[a >> 1] : 16'h0000;
            addr = a; data_in = d; write_en = we;
            tick();
            check($sformatf("rnd_data_%0d", i), data_out, exp_d);
            check($sformatf("rnd_oor_%0d", i), out_of_range, !in_r);
            if (we && in_r) model[a >> 1] = d;
        end
        write_en = 1'b0;

        // Directed load.
        img = {8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_load(img, 1'b0, 1'b0, "ld1");
        addr = 16'h0000; tick(); check("ld1_word0", data_out, 16'h2211);
        addr = 16'h0002; tick(); check("ld1_word1", data_out, 16'h4433);
        addr = 16'h0004; tick(); check("ld1_word2", data_out, 16'h0055);
        sweep("ld1");

        // Scribble words 0..3, then reload with toggling valid and a stray start.
        for (int i = 0; i < 4; i++) begin
            model[i] = 16'($urandom());
            addr = 16'(i * 2); data_in = model[i]; write_en = 1'b1;
            tick();
        end
        write_en = 1'b0;
        run_load(img, 1'b1, 1'b1, "ld2");
        sweep("ld2");

        // Zero-length image leaves RAM untouched.
        img = {8'h00, 8'h00};
        run_load(img, 1'b0, 1'b0, "ld0");
        sweep("ld0");

        // Short random image.
        n = $urandom_range(1, 41);
        img = {8'(n), 8'(n >> 8)};
        for (int i = 0; i < n; i++) img.push_back(8'($urandom()));
        run_load(img, 1'($urandom_range(0, 1)), 1'b0, "ldr");
        sweep("ldr");

        // Image longer than the RAM: the tail is consumed and dropped.
        n = MEMB + 3;
        img = {8'(n), 8'(n >> 8)};
        for (int i = 0; i < n; i++) img.push_back(8'($urandom()));
        run_load(img, 1'b0, 1'b0, "ldbig");
        sweep("ldbig");

        // Reset in the middle of a 6-byte load.
        for (int i = 0; i < 4; i++) begin
            model[i] = 16'($urandom());
            addr = 16'(i * 2); data_in = model[i]; write_en = 1'b1;
            tick();
        end
        write_en = 1'b0;
        b0 = 8'($urandom()); b1 = 8'($urandom()); b2 = 8'($urandom());
        img = {8'h06, 8'h00, b0, b1, b2};
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < img.size(); i++) begin
            load_valid = 1'b1;
            load_data  = img[i];
            tick();
        end
        load_valid = 1'b0;
        check("mid_loading_before_reset", loading, 1);
        reset = 1'b0;
        tick();
        check("mid_cpu_reset", cpu_reset, 1);
        check("mid_ready", load_ready, 0);
        check("mid_loading", loading, 0);
        check("mid_data_out", data_out, 0);
        reset = 1'b1;
        model[0] = {b1, b0};
        sweep("mid");

        // Loader still works after the aborted load.
        img = {8'h01, 8'h00, 8'h5A};
        run_load(img, 1'b0, 1'b0, "ldpost");
        addr = 16'h0000; tick(); check("ldpost_word0", data_out, 16'h005A);
        sweep("ldpost");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
